// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus blocks: state encoding,
// ctrl bit positions, command bytes and default timing.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT_PASS = 3'd0,
        IDLE      = 3'd1,
        SETUP     = 3'd2,
        PULSE     = 3'd3,
        HOLD      = 3'd4,
        WAIT      = 3'd5
    } lcdState_e;

    localparam int CTRL_RS = 0;
    localparam int CTRL_RW = 1;
    localparam int CTRL_E  = 2;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int DEF_CLKS_PER_US  = 50;
    localparam int DEF_E_SETUP_CLKS = 3;
    localparam int DEF_E_PULSE_CLKS = 25;
    localparam int DEF_E_HOLD_CLKS  = 3;
    localparam int DEF_EXEC_US      = 40;
    localparam int DEF_LONG_EXEC_US = 1640;

    localparam int US_W = 11;

    // Clear and both Return Home encodings (bit 0 is don't-care) need the long wait.
    function automatic logic isLongCmd(input logic rsBit, input logic [7:0] cmd);
        return !rsBit && (cmd == CMD_CLEAR || cmd == CMD_HOME || cmd == (CMD_HOME | 8'h01));
    endfunction

endpackage

// File: rtl/lcd_us_timer.sv
// Microsecond timer: prescaler producing a 1-cycle usTick plus a us counter
// that flags the final cycle of a loaded wait.
module lcd_us_timer
    import lcd_pkg::*;
#(
    parameter int CLKS_PER_US = DEF_CLKS_PER_US
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            start,
    input  logic [US_W-1:0] loadUs,
    output logic            usTick,
    output logic            expired
);

    localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    logic [PRE_W-1:0] preCnt;
    logic [US_W-1:0]  usCnt;
    logic [US_W-1:0]  target;

    assign usTick  = !start && (preCnt == PRE_W'(CLKS_PER_US - 1));
    // High on the last cycle of the wait, so the caller leaves on this edge.
    assign expired = usTick && (usCnt == target - US_W'(1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            preCnt <= '0;
            usCnt  <= '0;
            target <= '0;
        end else if (start) begin
            preCnt <= '0;
            usCnt  <= '0;
            target <= loadUs;
        end else if (usTick) begin
            preCnt <= '0;
            usCnt  <= usCnt + US_W'(1);
        end else begin
            preCnt <= preCnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// LCD bus owner: passes the init sequencer through until init completes, then
// round-robins two clients into timed E-strobed writes with execution waits.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
    parameter int E_SETUP_CLKS = DEF_E_SETUP_CLKS,
    parameter int E_PULSE_CLKS = DEF_E_PULSE_CLKS,
    parameter int E_HOLD_CLKS  = DEF_E_HOLD_CLKS,
    parameter int EXEC_US      = DEF_EXEC_US,
    parameter int LONG_EXEC_US = DEF_LONG_EXEC_US
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       init_done,
    input  logic [7:0] init_dOut,
    input  logic [2:0] init_ctrl,
    input  logic [1:0] req,
    input  logic [1:0] rs,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic [7:0] dOut,
    output logic [2:0] ctrl,
    output logic       busy
);

    localparam int CYC_MAX = (E_PULSE_CLKS > CLKS_PER_US) ? E_PULSE_CLKS : CLKS_PER_US;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    lcdState_e        state;
    logic             doneSeen;
    logic             rrLast;
    logic [CYC_W-1:0] cycCnt;
    logic [7:0]       dReg;
    logic             rsReg;
    logic             eReg;
    logic             longWait;

    logic             winner;
    logic             timerStart;
    logic             usTick;
    logic             expired;
    logic [US_W-1:0]  waitUs;

    always_comb begin
        winner = 1'b0;
        if (req == 2'b10)
            winner = 1'b1;
        else if (req == 2'b11)
            winner = ~rrLast;
    end

    assign gnt        = (state == IDLE && req != 2'b00) ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);
    assign timerStart = (state == HOLD) && (cycCnt == CYC_W'(E_HOLD_CLKS - 1));
    assign waitUs     = longWait ? US_W'(LONG_EXEC_US) : US_W'(EXEC_US);

    // Once init has completed the bus belongs to the arbiter for good.
    always_comb begin
        dOut = init_dOut;
        ctrl = init_ctrl;
        if (doneSeen) begin
            dOut          = dReg;
            ctrl          = '0;
            ctrl[CTRL_RS] = rsReg;
            ctrl[CTRL_E]  = eReg;
        end
    end

    lcd_us_timer #(
        .CLKS_PER_US(CLKS_PER_US)
    ) usTimer (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .start  (timerStart),
        .loadUs (waitUs),
        .usTick (usTick),
        .expired(expired)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= INIT_PASS;
            doneSeen <= 1'b0;
            rrLast   <= 1'b1;
            cycCnt   <= '0;
            dReg     <= '0;
            rsReg    <= 1'b0;
            eReg     <= 1'b0;
            longWait <= 1'b0;
        end else begin
            case (state)
                INIT_PASS: begin
                    if (init_done) begin
                        doneSeen <= 1'b1;
                        cycCnt   <= '0;
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    if (req != 2'b00) begin
                        dReg     <= winner ? data1 : data0;
                        rsReg    <= rs[winner];
                        longWait <= isLongCmd(rs[winner], winner ? data1 : data0);
                        rrLast   <= winner;
                        cycCnt   <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cycCnt == CYC_W'(E_SETUP_CLKS - 1)) begin
                        cycCnt <= '0;
                        eReg   <= 1'b1;
                        state  <= PULSE;
                    end else begin
                        cycCnt <= cycCnt + CYC_W'(1);
                    end
                end
                PULSE: begin
                    if (cycCnt == CYC_W'(E_PULSE_CLKS - 1)) begin
                        cycCnt <= '0;
                        eReg   <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        cycCnt <= cycCnt + CYC_W'(1);
                    end
                end
                HOLD: begin
                    if (timerStart) begin
                        cycCnt <= '0;
                        state  <= WAIT;
                    end else begin
                        cycCnt <= cycCnt + CYC_W'(1);
                    end
                end
                WAIT: begin
                    if (expired) begin
                        cycCnt <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= INIT_PASS;
            endcase
        end
    end

endmodule
